switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Conditions raw slide-switch inputs before they reach the 8-bit switch PIO read port (in_port).
//   Per bit: synchronises the asynchronous pad signal into clk, rejects contact bounce with a
//   stability counter, and emits a one-cycle change pulse.
//   Sits between the FPGA switch pins and the switch PIO, in the same clk domain as the PIO.
// PARAMETERS
//   WIDTH            8      number of switch bits handled in parallel
//   SYNC_STAGES      2      flip-flops in the synchroniser chain per bit; must be >= 2
//   DEBOUNCE_CYCLES  50000  consecutive stable cycles before the output follows (1 ms at 50 MHz); must be >= 1
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width; derived, not overridden
// PORTS
//   clk            in   1      system clock; all logic on its rising edge
//   reset          in   1      synchronous, active-high reset
//   sw_raw         in   WIDTH  asynchronous switch pins
//   sw_debounced   out  WIDTH  debounced, synchronous switch levels; drives the PIO in_port
//   sw_changed     out  WIDTH  one-cycle pulse per bit when that bit of sw_debounced updates
//   any_change     out  1      OR of sw_changed, same cycle
// BEHAVIOUR
//   - Reset: while reset=1 at a clk edge, clear all synchroniser flops, counters, sw_debounced,
//     sw_changed and any_change to 0. No output is X after the first reset edge.
//   - Synchroniser: sw_raw[i] passes through SYNC_STAGES flops. sync[i] is the last-stage output.
//   - Per-bit counter cnt[i], CNT_W bits. Evaluate at each edge with reset=0:
//       sync[i] == sw_debounced[i]           -> cnt[i] <= 0; no change
//       sync[i] != sw_debounced[i] and
//         cnt[i] <  DEBOUNCE_CYCLES-1        -> cnt[i] <= cnt[i]+1
//       sync[i] != sw_debounced[i] and
//         cnt[i] == DEBOUNCE_CYCLES-1        -> sw_debounced[i] <= sync[i]; cnt[i] <= 0;
//                                               sw_changed[i] <= 1
//   - sw_changed[i] is 0 on every edge other than the update edge. Width is exactly 1 cycle.
//   - any_change is registered in the same cycle as sw_changed.
//   - Latency: a clean level change on sw_raw, set up before edge 0, appears on sw_debounced after
//     edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges.
//   - Glitch rejection: if sync[i] returns to sw_debounced[i] before the count completes, the
//     counter clears and the output never toggles. A later mismatch restarts counting from 0.
//   - DEBOUNCE_CYCLES=1: the output follows sync one edge after the first mismatch, with no filtering.
//   - Bits are fully independent. Simultaneous updates on several bits pulse several sw_changed
//     bits in the same cycle, with any_change=1 once.
//   - The counter never exceeds DEBOUNCE_CYCLES-1, so it has no wrap-around.
//   - Reset mid-count discards the count. After reset release, a held-high switch is re-debounced
//     from 0 and produces a normal sw_changed pulse.
//   - Elaboration: $error if SYNC_STAGES<2 or DEBOUNCE_CYCLES<1.
// TESTING (bench uses WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1 Hold reset for 3 edges with sw_raw=8'hFF -> sw_debounced=0, sw_changed=0, any_change=0
//     throughout reset.
//   2 After reset, sw_raw=8'h01 set before edge 0 and held -> sw_debounced=8'h01 after edge 5.
//     sw_changed=8'h01 and any_change=1 for exactly that cycle, 0 after edge 6.
//   3 Bounce: sw_raw[3] high for 3 cycles, low for 1, then high and held -> output does not rise
//     on the first burst. It rises 6 edges after the final rising edge, with one pulse.
//   4 Single-cycle glitch sw_raw=8'h80 for 1 cycle -> sw_debounced stays 8'h00 and
//     sw_changed never asserts.
//   5 sw_raw 8'h00->8'hA5 simultaneously -> sw_debounced=8'hA5 and sw_changed=8'hA5 on the
//     same cycle, any_change=1 once.
//   6 Assert reset for 1 edge when the bit-0 count reaches 2 (sw_raw=8'h01 held) -> all state
//     clears. sw_debounced=8'h01 appears 6 edges after reset release, with one pulse.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit synchroniser, stability-count debouncer and one-cycle change pulse
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  deb_q, deb_d, chg_q, chg_d;
  logic                              any_q;
  logic [WIDTH-1:0]                  sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // A bit only moves after LAST+1 consecutive mismatching edges; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    chg_d = '0;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync[i] != deb_q[i]) begin
        deb_d[i] = (cnt_q[i] == LAST) ? sync[i] : deb_q[i];
        chg_d[i] = (cnt_q[i] == LAST);
        cnt_d[i] = (cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
      chg_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      chg_q  <= chg_d;
      any_q  <= |chg_d;
    end
  end
  assign sw_debounced = deb_q;
  assign sw_changed   = chg_q;
  assign any_change   = any_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed steps with a queue of hand-derived expectations per clock edge
module tb_switch_debouncer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_raw;
  logic [7:0] sw_debounced, sw_changed;
  logic       any_change;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct packed {
    logic [7:0] d;
    logic [7:0] c;
    logic       a;
  } exp_t;
  exp_t sb[$];
  switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_debounced(sw_debounced),
    .sw_changed(sw_changed),
    .any_change(any_change)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [7:0] raw, input logic rst, input logic [7:0] ed,
                      input logic [7:0] ec, input string tag);
    exp_t e;
    sw_raw = raw;
    reset  = rst;
    sb.push_back('{d: ed, c: ec, a: (ec != 8'h00)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    assert (sw_debounced === e.d) else begin
      n_err++;
      $error("FAIL %s sw_debounced got %h exp %h", tag, sw_debounced, e.d);
    end
    n_cmp++;
    assert (sw_changed === e.c) else begin
      n_err++;
      $error("FAIL %s sw_changed got %h exp %h", tag, sw_changed, e.c);
    end
    n_cmp++;
    assert (any_change === e.a) else begin
      n_err++;
      $error("FAIL %s any_change got %b exp %b", tag, any_change, e.a);
    end
  endtask
  task automatic hold(input logic [7:0] raw, input int n, input logic [7:0] ed, input string tag);
    for (int k = 0; k < n; k++) step(raw, 1'b0, ed, 8'h00, tag);
  endtask
  initial begin
    reset  = 1'b1;
    sw_raw = 8'hFF;
    for (int k = 0; k < 3; k++) step(8'hFF, 1'b1, 8'h00, 8'h00, "reset");
    hold(8'h01, 5, 8'h00, "rise_wait");
    step(8'h01, 1'b0, 8'h01, 8'h01, "rise_pulse");
    hold(8'h01, 2, 8'h01, "rise_after");
    hold(8'h09, 3, 8'h01, "bounce_hi");
    hold(8'h01, 1, 8'h01, "bounce_lo");
    hold(8'h09, 5, 8'h01, "bounce_wait");
    step(8'h09, 1'b0, 8'h09, 8'h08, "bounce_pulse");
    hold(8'h09, 2, 8'h09, "bounce_after");
    hold(8'h89, 1, 8'h09, "glitch");
    hold(8'h09, 8, 8'h09, "glitch_after");
    hold(8'h00, 5, 8'h09, "fall_wait");
    step(8'h00, 1'b0, 8'h00, 8'h09, "fall_pulse");
    hold(8'h00, 1, 8'h00, "fall_after");
    hold(8'hA5, 5, 8'h00, "multi_wait");
    step(8'hA5, 1'b0, 8'hA5, 8'hA5, "multi_pulse");
    hold(8'hA5, 2, 8'hA5, "multi_after");
    hold(8'h00, 5, 8'hA5, "clear_wait");
    step(8'h00, 1'b0, 8'h00, 8'hA5, "clear_pulse");
    hold(8'h00, 1, 8'h00, "clear_after");
    hold(8'h01, 4, 8'h00, "midcnt");
    step(8'h01, 1'b1, 8'h00, 8'h00, "midreset");
    hold(8'h01, 5, 8'h00, "rerun_wait");
    step(8'h01, 1'b0, 8'h01, 8'h01, "rerun_pulse");
    hold(8'h01, 2, 8'h01, "rerun_after");
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
